// File: rtl/sram_controller_if.sv
// Pipeline-side and SRAM-side signal bundle for sram_controller.
// master = pipeline/SRAM environment, slave = controller.
interface sram_controller_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        freeze;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic [15:0] SRAM_DQ_in;
  logic        SRAM_DQ_oe;
  logic        SRAM_WE_N;

  modport master (
    output MEM_R_EN, MEM_W_EN, address, wdata,
    output SRAM_DQ_in,
    input  rdata, freeze,
    input  SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, wdata,
    input  SRAM_DQ_in,
    output rdata, freeze,
    output SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );
endinterface

// File: rtl/sram_controller.sv
// 32-bit pipeline to 16-bit SRAM controller, two half-word accesses.
// Optional one-entry read buffer: define SRAM_CTRL_READ_BUFFER_EN.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  sram_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, LOW, HIGH, DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [16:0] idx_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [15:0] lo_q;
  logic [31:0] rdata_q;
  logic        req;
  logic        last;
  logic        hit;
  logic        unused;

  assign req    = bus.MEM_R_EN | bus.MEM_W_EN;
  assign last   = (cnt == LAST);
  assign unused = ^{bus.address[31:19], bus.address[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (req && !hit) begin
          idx_q   <= bus.address[18:2];
          wdata_q <= bus.wdata;
          wr_q    <= bus.MEM_W_EN;
          cnt     <= '0;
          state   <= LOW;
        end
        LOW: if (last) begin
          cnt   <= '0;
          state <= HIGH;
          if (!wr_q) lo_q <= bus.SRAM_DQ_in;
        end else begin
          cnt <= cnt + 4'd1;
        end
        HIGH: if (last) begin
          cnt   <= '0;
          state <= DONE;
          // both halves are committed together so rdata only moves on completion
          if (!wr_q) rdata_q <= {bus.SRAM_DQ_in, lo_q};
        end else begin
          cnt <= cnt + 4'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_CTRL_READ_BUFFER_EN
  logic        buf_v;
  logic [16:0] buf_idx;
  logic [31:0] buf_data;

  assign hit = buf_v && (state == IDLE)
            && bus.MEM_R_EN && !bus.MEM_W_EN
            && (buf_idx == bus.address[18:2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v    <= 1'b0;
      buf_idx  <= '0;
      buf_data <= '0;
    end else if (state == IDLE && bus.MEM_W_EN) begin
      buf_v <= 1'b0;
    end else if (state == HIGH && last && !wr_q) begin
      buf_v    <= 1'b1;
      buf_idx  <= idx_q;
      buf_data <= {bus.SRAM_DQ_in, lo_q};
    end
  end

  assign bus.rdata = hit ? buf_data : rdata_q;
`else
  assign hit       = 1'b0;
  assign bus.rdata = rdata_q;
`endif

  assign bus.freeze = req && (state != DONE) && !hit;

  always_comb begin
    bus.SRAM_ADDR   = '0;
    bus.SRAM_DQ_out = '0;
    bus.SRAM_DQ_oe  = 1'b0;
    bus.SRAM_WE_N   = 1'b1;
    if (state == LOW || state == HIGH) begin
      bus.SRAM_ADDR  = {idx_q, state == HIGH};
      bus.SRAM_DQ_oe = wr_q;
      if (wr_q) begin
        bus.SRAM_DQ_out = (state == HIGH)
                        ? wdata_q[31:16]
                        : wdata_q[15:0];
      end
      // strobe releases one cycle early so data is held past WE_N rise
      bus.SRAM_WE_N = !(wr_q && !last);
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: driver queues expectations,
// a negedge monitor checks SRAM strobes and pipeline completions.
module tb_sram_controller;

  typedef struct {
    logic [31:0] rd;
    int          fz;
  } pexp_t;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
  } wexp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   fcnt;

  pexp_t pq[$];
  wexp_t wq[$];
  logic [15:0] mem [0:63];

  sram_controller_if sif ();

  sram_controller #(.WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  assign sif.SRAM_DQ_in = mem[sif.SRAM_ADDR[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SRAM_CTRL_READ_BUFFER_EN
  localparam int HITF = 0;
`else
  localparam int HITF = 5;
`endif

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // monitor: SRAM model, strobe and completion checks
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    mem[6'h22] = 16'h1111;
    mem[6'h23] = 16'h2222;
    fcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fcnt = 0;
      end else begin
        if (sif.SRAM_WE_N === 1'b0) begin
          if (wq.size() == 0) begin
            chk("extra_strobe", {14'b0, sif.SRAM_ADDR}, 32'hFFFFFFFF);
          end else begin
            wexp_t w;
            w = wq.pop_front();
            chk("strobe_addr", {14'b0, sif.SRAM_ADDR}, {14'b0, w.a});
            chk("strobe_data", {16'b0, sif.SRAM_DQ_out}, {16'b0, w.d});
            chk("strobe_oe", {31'b0, sif.SRAM_DQ_oe}, 32'd1);
          end
          mem[sif.SRAM_ADDR[5:0]] = sif.SRAM_DQ_out;
        end
        if (sif.MEM_R_EN || sif.MEM_W_EN) begin
          if (sif.freeze) begin
            fcnt++;
          end else if (pq.size() == 0) begin
            chk("extra_done", 32'd1, 32'd0);
          end else begin
            pexp_t p;
            p = pq.pop_front();
            chk("rdata", sif.rdata, p.rd);
            chk("freeze_len", fcnt, p.fz);
            fcnt = 0;
          end
        end
        if (!sif.freeze) begin
          chk("idle_bus",
              {12'b0, sif.SRAM_ADDR, sif.SRAM_DQ_oe, sif.SRAM_WE_N},
              32'd1);
        end
      end
    end
  end

  task automatic op(input logic r, input logic w,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] exp_rd, input int exp_f);
    int n;
    pexp_t p;
    wexp_t x;
    p.rd = exp_rd;
    p.fz = exp_f;
    pq.push_back(p);
    if (w) begin
      x.a = {a[18:2], 1'b0};
      x.d = d[15:0];
      wq.push_back(x);
      x.a = {a[18:2], 1'b1};
      x.d = d[31:16];
      wq.push_back(x);
    end
    sif.MEM_R_EN = r;
    sif.MEM_W_EN = w;
    sif.address  = a;
    sif.wdata    = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sif.freeze && n < 40);
    if (sif.freeze) begin
      total++;
      bad++;
      $display("FAIL timeout: freeze still %b want 0", sif.freeze);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int c);
    sif.MEM_R_EN = 1'b0;
    sif.MEM_W_EN = 1'b0;
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    wexp_t x;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    sif.MEM_R_EN = 1'b0;
    sif.MEM_W_EN = 1'b0;
    sif.address  = '0;
    sif.wdata    = '0;
    @(negedge clk);
    chk("rst_rdata", sif.rdata, 32'h0);
    chk("rst_freeze", {31'b0, sif.freeze}, 32'd0);
    chk("rst_we_n", {31'b0, sif.SRAM_WE_N}, 32'd1);
    chk("rst_oe", {31'b0, sif.SRAM_DQ_oe}, 32'd0);
    chk("rst_addr", {14'b0, sif.SRAM_ADDR}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    op(0, 1, 32'h40, 32'hDEADBEEF, 32'h0, 5);
    op(1, 0, 32'h40, 32'h0, 32'hDEADBEEF, 5);
    op(1, 0, 32'h40, 32'h0, 32'hDEADBEEF, HITF);
    op(1, 1, 32'h40, 32'h12345678, 32'hDEADBEEF, 5);
    idle(1);
    op(1, 0, 32'h40, 32'h0, 32'h12345678, 5);
    op(1, 0, 32'h44, 32'h0, 32'h22221111, 5);
    op(1, 0, 32'h40, 32'h0, 32'h12345678, 5);
    idle(2);

    // abort a write in its HIGH phase
    x.a = 18'h24; x.d = 16'hF00D; wq.push_back(x);
    x.a = 18'h25; x.d = 16'hCAFE; wq.push_back(x);
    sif.MEM_W_EN = 1'b1;
    sif.address  = 32'h48;
    sif.wdata    = 32'hCAFEF00D;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sif.SRAM_ADDR[0] !== 1'b1 && n < 40);
    chk("reach_high", {31'b0, sif.SRAM_ADDR[0]}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_we_n", {31'b0, sif.SRAM_WE_N}, 32'd1);
    chk("abort_oe", {31'b0, sif.SRAM_DQ_oe}, 32'd0);
    chk("abort_addr", {14'b0, sif.SRAM_ADDR}, 32'd0);
    chk("abort_freeze", {31'b0, sif.freeze}, 32'd1);
    chk("abort_rdata", sif.rdata, 32'h0);
    sif.MEM_W_EN = 1'b0;
    @(negedge clk);
    chk("abort_freeze_lo", {31'b0, sif.freeze}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    op(1, 0, 32'h40, 32'h0, 32'h12345678, 5);
    op(1, 0, 32'h40, 32'h0, 32'h12345678, HITF);
    idle(4);

    chk("strobes_left", wq.size(), 32'd0);
    chk("dones_left", pq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
